video_capture: RTL and testbench

Receive-side counterpart of the frame synthesizer's video output. Consumes the RGB332 pixel stream and its timing signals (hsync, vsync, blank), recovers active-area pixel coordinates and measures line and frame geometry. On request, it captures one decimated window of a single frame into a capture RAM through a 14-bit write port. Used for on-chip self-test of the GPU path and for screenshot readback by the CPU.

---
 rtl/video_capture_pkg.sv | 27 ++
 rtl/video_timing_meter.sv | 84 ++++++++
 rtl/video_capture.sv | 154 +++++++++++++++
 tb/tb_video_capture.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_capture_pkg.sv
// Shared definitions for the video capture path and the timing generator.
package video_capture_pkg;

  localparam int unsigned H_ACTIVE_DEFAULT = 640;
  localparam int unsigned V_ACTIVE_DEFAULT = 480;
  localparam int unsigned CAP_AW           = 14;
  localparam int unsigned COORD_W          = 12;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE,
    DONE
  } cap_state_t;

  // Coordinate increment that sticks at all-ones instead of wrapping.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/video_timing_meter.sv
// Registers the incoming video stream, recovers active-area coordinates and
// measures line/frame geometry against the expected active size.
module video_timing_meter
  import video_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEFAULT
) (
  input  logic               clkPixel,
  input  logic               reset,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               blank,
  input  rgb332_t            pixel,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output rgb332_t            pixel_r,
  output logic               active,
  output logic               frame_start,
  output logic               line_end,
  output logic [COORD_W-1:0] width_meas,
  output logic [COORD_W-1:0] height_meas,
  output logic               geom_err
);

  logic hs_r, vs_r, bl_r;
  logic vs_q, bl_q;
  logic seen_frame;

  // hsync is registered alongside the other inputs; line geometry comes from blank.
  logic unused_hs;
  assign unused_hs = hs_r;

  assign frame_start = vs_q & ~vs_r;
  assign line_end    = ~bl_q & bl_r;
  assign active      = ~bl_r;

  // Geometry is only trusted once a frame start has been seen, so the
  // partial frame after reset never flags an error.
  assign geom_err = seen_frame &
                    ((line_end    & (x != COORD_W'(H_ACTIVE))) |
                     (frame_start & (y != COORD_W'(V_ACTIVE))));

  // Input register stage plus edge-detector history (primed to idle levels).
  always_ff @(posedge clkPixel) begin
    if (reset) begin
      hs_r    <= 1'b1;
      vs_r    <= 1'b1;
      bl_r    <= 1'b1;
      pixel_r <= '0;
      vs_q    <= 1'b1;
      bl_q    <= 1'b1;
    end else begin
      hs_r    <= hsync;
      vs_r    <= vsync;
      bl_r    <= blank;
      pixel_r <= pixel;
      vs_q    <= vs_r;
      bl_q    <= bl_r;
    end
  end

  // Coordinate counters and geometry measurement registers.
  always_ff @(posedge clkPixel) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      width_meas  <= '0;
      height_meas <= '0;
      seen_frame  <= 1'b0;
    end else begin
      x <= bl_r ? '0 : sat_inc(x);
      if (frame_start) begin
        y           <= '0;
        height_meas <= y;
        seen_frame  <= 1'b1;
      end else if (line_end) begin
        y <= sat_inc(y);
      end
      if (line_end) width_meas <= x;
    end
  end

endmodule

// File: rtl/video_capture.sv
// Captures one decimated window of a frame into a capture RAM on request and
// reports measured video geometry.
module video_capture
  import video_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int unsigned WIN_X    = 0,
  parameter int unsigned WIN_Y    = 0,
  parameter int unsigned WIN_W    = 80,
  parameter int unsigned WIN_H    = 60,
  parameter int unsigned DEC_LOG2 = 3
) (
  input  logic              clkPixel,
  input  logic              reset,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank,
  input  logic [7:0]        pixel,
  input  logic              arm,
  output logic              busy,
  output logic              done,
  output logic              cap_we,
  output logic [CAP_AW-1:0] cap_addr,
  output logic [7:0]        cap_data,
  output logic [11:0]       width_meas,
  output logic [11:0]       height_meas,
  output logic              timing_err
);

  localparam int unsigned X_SPAN    = WIN_W << DEC_LOG2;
  localparam int unsigned Y_SPAN    = WIN_H << DEC_LOG2;
  localparam int unsigned DEC_MASK  = (1 << DEC_LOG2) - 1;
  localparam logic [CAP_AW-1:0] LAST_ADDR = CAP_AW'(WIN_W * WIN_H - 1);

  if (WIN_W * WIN_H > (1 << CAP_AW)) begin : g_chk_size
    $error("capture window exceeds capture RAM");
  end
  if (WIN_X + X_SPAN > H_ACTIVE) begin : g_chk_x
    $error("capture window exceeds active width");
  end
  if (WIN_Y + Y_SPAN > V_ACTIVE) begin : g_chk_y
    $error("capture window exceeds active height");
  end

  logic [COORD_W-1:0] x, y;
  rgb332_t            pixel_r;
  logic               active, frame_start, unused_line_end, geom_err;

  video_timing_meter #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_meter (
    .clkPixel   (clkPixel),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank      (blank),
    .pixel      (rgb332_t'(pixel)),
    .x          (x),
    .y          (y),
    .pixel_r    (pixel_r),
    .active     (active),
    .frame_start(frame_start),
    .line_end   (unused_line_end),
    .width_meas (width_meas),
    .height_meas(height_meas),
    .geom_err   (geom_err)
  );

  // Offsets wrap to huge values left/above the window, so one unsigned
  // compare covers both window edges.
  logic [31:0] dx, dy;
  logic        sample;
  assign dx     = 32'(x) - WIN_X;
  assign dy     = 32'(y) - WIN_Y;
  assign sample = active & (dx < X_SPAN) & (dy < Y_SPAN) &
                  ((dx & DEC_MASK) == '0) & ((dy & DEC_MASK) == '0);

  cap_state_t        state, state_n;
  logic [CAP_AW-1:0] addr, addr_n, cap_addr_n;
  logic [7:0]        cap_data_n;
  logic              cap_we_n, busy_n, done_n, err_n;

  // State, address counter and registered outputs.
  always_ff @(posedge clkPixel) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      cap_we     <= cap_we_n;
      cap_addr   <= cap_addr_n;
      cap_data   <= cap_data_n;
      busy       <= busy_n;
      done       <= done_n;
      timing_err <= err_n;
    end
  end

  // Next-state and next-output logic for the capture sequencer.
  always_comb begin
    state_n    = state;
    addr_n     = addr;
    cap_we_n   = 1'b0;
    cap_addr_n = cap_addr;
    cap_data_n = cap_data;
    busy_n     = busy;
    done_n     = 1'b0;
    err_n      = timing_err | geom_err;
    unique case (state)
      IDLE: begin
        // done is still high one cycle after DONE; an arm there is dropped.
        if (arm && !done) begin
          state_n = WAIT_FRAME;
          busy_n  = 1'b1;
          err_n   = 1'b0;
        end
      end
      WAIT_FRAME: begin
        if (frame_start) begin
          state_n = CAPTURE;
          addr_n  = '0;
        end
      end
      CAPTURE: begin
        if (frame_start) begin
          err_n  = 1'b1;
          addr_n = '0;
        end else if (sample) begin
          cap_we_n   = 1'b1;
          cap_addr_n = addr;
          cap_data_n = pixel_r;
          addr_n     = addr + 1'b1;
          if (addr == LAST_ADDR) state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture with a write scoreboard.
module tb_video_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1, hsync = 1'b1, vsync = 1'b1, blank = 1'b1, arm = 1'b0;
  logic [7:0]  pixel = '0;

  logic        busy, done, cap_we, timing_err;
  logic [13:0] cap_addr;
  logic [7:0]  cap_data;
  logic [11:0] width_meas, height_meas;

  logic        busy2, done2, cap_we2, timing_err2;
  logic [13:0] cap_addr2;
  logic [7:0]  cap_data2;
  logic [11:0] width_meas2, height_meas2;

  always #5 clk = ~clk;

  video_capture #(
    .H_ACTIVE(16), .V_ACTIVE(8), .WIN_X(0), .WIN_Y(0),
    .WIN_W(4), .WIN_H(2), .DEC_LOG2(2)
  ) dut (
    .clkPixel(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .blank(blank),
    .pixel(pixel), .arm(arm), .busy(busy), .done(done), .cap_we(cap_we),
    .cap_addr(cap_addr), .cap_data(cap_data), .width_meas(width_meas),
    .height_meas(height_meas), .timing_err(timing_err)
  );

  // Full-width instance for line/frame measurement at 640 pixels per line.
  video_capture #(
    .H_ACTIVE(640), .V_ACTIVE(4), .WIN_X(0), .WIN_Y(0),
    .WIN_W(4), .WIN_H(1), .DEC_LOG2(2)
  ) dut_meas (
    .clkPixel(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .blank(blank),
    .pixel(pixel), .arm(1'b0), .busy(busy2), .done(done2), .cap_we(cap_we2),
    .cap_addr(cap_addr2), .cap_data(cap_data2), .width_meas(width_meas2),
    .height_meas(height_meas2), .timing_err(timing_err2)
  );

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   wr_cnt = 0, done_cnt = 0;
  int   first_we_cyc = -1, last_we_cyc = -1, done_cyc = -1;
  bit   m_pend = 0, m_cap = 0;
  int   m_addr = 0, t_first = -1;
  int   w0, d0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cap_we) begin
      wr_cnt++;
      last_we_cyc = cyc;
      if (sb.size() == 0) begin
        chk("spurious_we", 32'(cap_we), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("cap_addr", 32'(cap_addr), 32'(mon_e.addr));
        chk("cap_data", 32'(cap_data), 32'(mon_e.data));
        if (mon_e.addr == 14'd0) first_we_cyc = cyc;
      end
    end
  end

  task automatic step(input logic hs, input logic vs, input logic bl, input logic [7:0] px);
    @(posedge clk);
    #1;
    hsync = hs; vsync = vs; blank = bl; pixel = px;
  endtask

  task automatic vpulse();
    step(1'b1, 1'b0, 1'b1, 8'd0);
    if (m_pend || m_cap) begin
      m_cap  = 1;
      m_addr = 0;
      m_pend = 0;
    end
    step(1'b1, 1'b0, 1'b1, 8'd0);
    step(1'b1, 1'b1, 1'b1, 8'd0);
    step(1'b1, 1'b1, 1'b1, 8'd0);
  endtask

  // One active pixel; the window is 16x8 pixels sampled every 4th column/line.
  task automatic pix(input int xx, input int yy);
    logic [7:0] px;
    exp_t       e;
    px = 8'(xx + 16 * yy);
    step(1'b1, 1'b1, 1'b0, px);
    if (m_cap && (xx % 4 == 0) && (yy % 4 == 0) && xx < 16 && yy < 8) begin
      e.addr = 14'(m_addr);
      e.data = px;
      sb.push_back(e);
      if (m_addr == 0) t_first = cyc;
      m_addr++;
      if (m_addr == 8) m_cap = 0;
    end
  endtask

  task automatic hblank();
    step(1'b1, 1'b1, 1'b1, 8'd0);
    step(1'b0, 1'b1, 1'b1, 8'd0);
    step(1'b0, 1'b1, 1'b1, 8'd0);
    step(1'b1, 1'b1, 1'b1, 8'd0);
  endtask

  task automatic line(input int yy, input int len);
    for (int xx = 0; xx < len; xx++) pix(xx, yy);
    hblank();
  endtask

  task automatic frame(input int w, input int n);
    vpulse();
    for (int yy = 0; yy < n; yy++) line(yy, w);
    step(1'b1, 1'b1, 1'b1, 8'd0);
    step(1'b1, 1'b1, 1'b1, 8'd0);
  endtask

  task automatic do_arm(input bit accepted);
    @(posedge clk); #1; arm = 1'b1;
    @(posedge clk); #1; arm = 1'b0;
    if (accepted) m_pend = 1;
  endtask

  task automatic settle();
    repeat (5) step(1'b1, 1'b1, 1'b1, 8'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_we", 32'(cap_we), 0);
    chk("rst_addr", 32'(cap_addr), 0);
    chk("rst_data", 32'(cap_data), 0);
    chk("rst_width", 32'(width_meas), 0);
    chk("rst_height", 32'(height_meas), 0);
    chk("rst_err", 32'(timing_err), 0);
    reset = 1'b0;

    // Nominal capture with latency checks
    frame(16, 8);
    do_arm(1);
    chk("busy_after_arm", 32'(busy), 1);
    w0 = wr_cnt; d0 = done_cnt;
    frame(16, 8);
    settle();
    chk("nom_writes", 32'(wr_cnt - w0), 8);
    chk("nom_done", 32'(done_cnt - d0), 1);
    chk("nom_err", 32'(timing_err), 0);
    chk("nom_busy", 32'(busy), 0);
    chk("nom_sb_left", 32'(sb.size()), 0);
    chk("lat_first_we", 32'(first_we_cyc), 32'(t_first + 2));
    chk("lat_done", 32'(done_cyc), 32'(last_we_cyc + 1));
    chk("width16", 32'(width_meas), 16);
    chk("height8", 32'(height_meas), 8);

    // Abort: new frame after 3 writes restarts at address 0
    do_arm(1);
    w0 = wr_cnt; d0 = done_cnt;
    vpulse();
    line(0, 10);
    frame(16, 8);
    settle();
    chk("abort_err", 32'(timing_err), 1);
    chk("abort_writes", 32'(wr_cnt - w0), 11);
    chk("abort_done", 32'(done_cnt - d0), 1);
    chk("abort_sb_left", 32'(sb.size()), 0);

    // Arm while busy is ignored; accepted arm clears the sticky error
    do_arm(1);
    chk("err_cleared_by_arm", 32'(timing_err), 0);
    w0 = wr_cnt; d0 = done_cnt;
    vpulse();
    line(0, 16);
    do_arm(0);
    chk("busy_during_cap", 32'(busy), 1);
    for (int yy = 1; yy < 8; yy++) line(yy, 16);
    settle();
    chk("rearm_writes", 32'(wr_cnt - w0), 8);
    chk("rearm_done", 32'(done_cnt - d0), 1);
    chk("rearm_err", 32'(timing_err), 0);

    // Reset after two writes
    do_arm(1);
    w0 = wr_cnt;
    vpulse();
    for (int xx = 0; xx < 7; xx++) pix(xx, 0);
    @(posedge clk); #1; reset = 1'b1; blank = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    m_cap = 0; m_pend = 0;
    chk("mid_rst_writes", 32'(wr_cnt - w0), 2);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_we", 32'(cap_we), 0);
    frame(16, 8);
    settle();
    chk("post_rst_no_writes", 32'(wr_cnt - w0), 2);
    do_arm(1);
    w0 = wr_cnt; d0 = done_cnt;
    frame(16, 8);
    settle();
    chk("post_rst_writes", 32'(wr_cnt - w0), 8);
    chk("post_rst_done", 32'(done_cnt - d0), 1);
    chk("post_rst_sb_left", 32'(sb.size()), 0);

    // Measurement at 640 pixels per line
    @(posedge clk); #1; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    frame(640, 4);
    frame(640, 4);
    vpulse();
    chk("width640", 32'(width_meas2), 640);
    chk("height4", 32'(height_meas2), 4);
    chk("meas_err_clean", 32'(timing_err2), 0);
    line(0, 640);
    line(1, 639);
    chk("width639", 32'(width_meas2), 639);
    chk("short_line_err", 32'(timing_err2), 1);
    line(2, 640);
    line(3, 640);
    frame(640, 4);
    chk("err_sticky", 32'(timing_err2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
